yazmac_oku: RTL and testbench

- Register-read / issue stage that directly consumes the decode stage's registered micro-op.
- Holds the 32x32 integer register file and a per-register scoreboard of pending writes.
- Substitutes operand values into the uop's UOP_RS1/UOP_RS2 fields and issues the uop to execute one cycle later.
- Raises duraklat_o, which is wired to the decoder's cek_duraklat_i, on RAW hazards or downstream stall.

---
 rtl/yazmac_oku_pkg.sv | 36 +++
 rtl/yazmac_obegi.sv | 32 +++
 rtl/yazmac_oku.sv | 119 +++++++++++
 tb/tb_yazmac_oku.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yazmac_oku_pkg.sv
// Shared micro-op layout and register-file constants for the register-read / issue stage.
// Field order mirrors the decoder's registered uop so the bus is passed around as a plain vector.
package yazmac_oku_pkg;

  localparam int YAZMAC_SAYISI = 32;
  localparam int YAZMAC_BIT    = 5;
  localparam int VERI_BIT      = 32;
  localparam int UOP_TAG_BIT   = 4;

  typedef struct packed {
    logic                   valid;
    logic [UOP_TAG_BIT-1:0] tag;
    logic [11:0]            csr_adres;
    logic [3:0]             csr_islem;
    logic [3:0]             amb;
    logic [3:0]             dal;
    logic                   yaz;
    logic                   taken;
    logic                   rd_alloc;
    logic [YAZMAC_BIT-1:0]  rd_addr;
    logic                   rs2_en;
    logic                   rs1_en;
    logic [VERI_BIT-1:0]    rs2;
    logic [VERI_BIT-1:0]    rs1;
    logic [VERI_BIT-1:0]    imm;
    logic [VERI_BIT-1:0]    pc;
  } uop_t;

  localparam int UOP_BIT = $bits(uop_t);

  // Source fields carry the register index in their low bits until operands are substituted.
  function automatic logic [YAZMAC_BIT-1:0] kaynak_adres(input logic [VERI_BIT-1:0] alan);
    return alan[YAZMAC_BIT-1:0];
  endfunction

endpackage

// File: rtl/yazmac_obegi.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
// Zero read latency; write lands on the next rising edge, no backpressure.
module yazmac_obegi
  import yazmac_oku_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [YAZMAC_BIT-1:0] oku1_adres,
  output logic [VERI_BIT-1:0]   oku1_veri,
  input  logic [YAZMAC_BIT-1:0] oku2_adres,
  output logic [VERI_BIT-1:0]   oku2_veri,
  input  logic                  yaz_gecerli,
  input  logic [YAZMAC_BIT-1:0] yaz_adres,
  input  logic [VERI_BIT-1:0]   yaz_veri
);

  logic [VERI_BIT-1:0] yazmaclar [YAZMAC_SAYISI];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < YAZMAC_SAYISI; i++) begin
        yazmaclar[i] <= '0;
      end
    end else if (yaz_gecerli && (yaz_adres != '0)) begin
      yazmaclar[yaz_adres] <= yaz_veri;
    end
  end

  assign oku1_veri = (oku1_adres == '0) ? '0 : yazmaclar[oku1_adres];
  assign oku2_veri = (oku2_adres == '0) ? '0 : yazmaclar[oku2_adres];

endmodule

// File: rtl/yazmac_oku.sv
// Register-read / issue: scoreboarded operand fetch with writeback bypass, one cycle to execute.
// Stalls decode on unresolved RAW or execute stall; holds its output while execute is stalled.
module yazmac_oku
  import yazmac_oku_pkg::*;
#(
  parameter int YAZMAC_SAYISI = yazmac_oku_pkg::YAZMAC_SAYISI,
  parameter int ETIKET_BIT    = UOP_TAG_BIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [UOP_BIT-1:0]    coz_uop_i,
  input  logic                  bosalt_i,
  input  logic                  yurut_duraklat_i,
  input  logic                  gy_yaz_gecerli_i,
  input  logic [YAZMAC_BIT-1:0] gy_yaz_adres_i,
  input  logic [VERI_BIT-1:0]   gy_yaz_veri_i,
  input  logic [ETIKET_BIT-1:0] gy_etiket_i,
  output logic                  duraklat_o,
  output logic [UOP_BIT-1:0]    yurut_uop_o
);

  uop_t                     giris;
  uop_t                     verilen;
  uop_t                     cikis_q;
  logic [YAZMAC_BIT-1:0]    rs1_adres;
  logic [YAZMAC_BIT-1:0]    rs2_adres;
  logic [VERI_BIT-1:0]      rf_veri1;
  logic [VERI_BIT-1:0]      rf_veri2;
  logic [VERI_BIT-1:0]      islenen1;
  logic [VERI_BIT-1:0]      islenen2;
  logic                     gy_aktif;
  logic                     bypass1;
  logic                     bypass2;
  logic                     engel1;
  logic                     engel2;
  logic                     tehlike;
  logic                     verilir;
  logic                     tahsis;
  logic [YAZMAC_SAYISI-1:0] mesgul;
  logic [ETIKET_BIT-1:0]    sahip [YAZMAC_SAYISI];

  assign giris     = coz_uop_i;
  assign rs1_adres = kaynak_adres(giris.rs1);
  assign rs2_adres = kaynak_adres(giris.rs2);

  yazmac_obegi u_obek (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .oku1_adres  (rs1_adres),
    .oku1_veri   (rf_veri1),
    .oku2_adres  (rs2_adres),
    .oku2_veri   (rf_veri2),
    .yaz_gecerli (gy_yaz_gecerli_i),
    .yaz_adres   (gy_yaz_adres_i),
    .yaz_veri    (gy_yaz_veri_i)
  );

  assign gy_aktif = gy_yaz_gecerli_i && (gy_yaz_adres_i != '0);
  assign bypass1  = gy_aktif && (gy_yaz_adres_i == rs1_adres);
  assign bypass2  = gy_aktif && (gy_yaz_adres_i == rs2_adres);

  // A pending operand is released in the same cycle its owning writer arrives on the bypass.
  assign engel1 = giris.valid && giris.rs1_en && (rs1_adres != '0) && mesgul[rs1_adres]
                  && !(bypass1 && (gy_etiket_i == sahip[rs1_adres]));
  assign engel2 = giris.valid && giris.rs2_en && (rs2_adres != '0) && mesgul[rs2_adres]
                  && !(bypass2 && (gy_etiket_i == sahip[rs2_adres]));
  assign tehlike = engel1 || engel2;

  assign duraklat_o = (tehlike || yurut_duraklat_i) && giris.valid && !bosalt_i && !rst_i;
  assign verilir    = giris.valid && !tehlike && !yurut_duraklat_i && !bosalt_i;
  assign tahsis     = verilir && giris.rd_alloc && (giris.rd_addr != '0);

  always_comb begin
    islenen1 = '0;
    islenen2 = '0;
    if (giris.rs1_en && (rs1_adres != '0)) begin
      islenen1 = bypass1 ? gy_yaz_veri_i : rf_veri1;
    end
    if (giris.rs2_en && (rs2_adres != '0)) begin
      islenen2 = bypass2 ? gy_yaz_veri_i : rf_veri2;
    end
    verilen     = giris;
    verilen.rs1 = islenen1;
    verilen.rs2 = islenen2;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cikis_q <= '0;
    end else if (bosalt_i) begin
      cikis_q <= '0;
    end else if (!yurut_duraklat_i) begin
      cikis_q <= verilir ? verilen : '0;
    end
  end

  assign yurut_uop_o = cikis_q;

  // Allocation takes priority over a same-cycle writeback to the same register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mesgul <= '0;
      for (int i = 0; i < YAZMAC_SAYISI; i++) begin
        sahip[i] <= '0;
      end
    end else begin
      for (int i = 1; i < YAZMAC_SAYISI; i++) begin
        if (tahsis && (giris.rd_addr == YAZMAC_BIT'(i))) begin
          mesgul[i] <= 1'b1;
          sahip[i]  <= ETIKET_BIT'(giris.tag);
        end else if (gy_aktif && (gy_yaz_adres_i == YAZMAC_BIT'(i))
                     && (gy_etiket_i == sahip[i])) begin
          mesgul[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_yazmac_oku.sv
// Bench for yazmac_oku: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_yazmac_oku;
  import yazmac_oku_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [UOP_BIT-1:0] coz_uop_i;
  logic               bosalt_i;
  logic               yurut_duraklat_i;
  logic               gy_yaz_gecerli_i;
  logic [4:0]         gy_yaz_adres_i;
  logic [31:0]        gy_yaz_veri_i;
  logic [3:0]         gy_etiket_i;
  logic               duraklat_o;
  logic [UOP_BIT-1:0] yurut_uop_o;

  yazmac_oku dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .coz_uop_i        (coz_uop_i),
    .bosalt_i         (bosalt_i),
    .yurut_duraklat_i (yurut_duraklat_i),
    .gy_yaz_gecerli_i (gy_yaz_gecerli_i),
    .gy_yaz_adres_i   (gy_yaz_adres_i),
    .gy_yaz_veri_i    (gy_yaz_veri_i),
    .gy_etiket_i      (gy_etiket_i),
    .duraklat_o       (duraklat_o),
    .yurut_uop_o      (yurut_uop_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers, pending-write flags and owning tags.
  logic [31:0] m_reg   [32];
  bit          m_busy  [32];
  logic [3:0]  m_owner [32];
  uop_t        m_out;
  logic        exp_stall;
  uop_t        exp_out;
  bit          exp_issue;
  logic        obs_stall;

  typedef struct {
    logic [4:0] rd;
    logic [3:0] tag;
  } inflight_t;
  inflight_t q[$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0; m_busy[i] = 0; m_owner[i] = '0;
    end
    m_out = '0;
  endtask

  function automatic logic [31:0] model_operand(logic en, logic [31:0] f);
    logic [4:0] r;
    r = f[4:0];
    if (!en || r == 0) return '0;
    if (gy_yaz_gecerli_i && gy_yaz_adres_i == r) return gy_yaz_veri_i;
    return m_reg[r];
  endfunction

  function automatic bit model_ready(logic en, logic [31:0] f);
    logic [4:0] r;
    r = f[4:0];
    if (!en || r == 0 || !m_busy[r]) return 1;
    return gy_yaz_gecerli_i && gy_yaz_adres_i == r && gy_etiket_i == m_owner[r];
  endfunction

  task automatic model_step();
    uop_t u;
    bit   hazard;
    u = coz_uop_i;
    hazard    = u.valid && !(model_ready(u.rs1_en, u.rs1) && model_ready(u.rs2_en, u.rs2));
    exp_stall = (hazard || yurut_duraklat_i) && u.valid && !bosalt_i;
    exp_issue = u.valid && !hazard && !yurut_duraklat_i && !bosalt_i;
    if (bosalt_i) exp_out = '0;
    else if (yurut_duraklat_i) exp_out = m_out;
    else if (exp_issue) begin
      exp_out     = u;
      exp_out.rs1 = model_operand(u.rs1_en, u.rs1);
      exp_out.rs2 = model_operand(u.rs2_en, u.rs2);
    end else exp_out = '0;
    if (gy_yaz_gecerli_i && gy_yaz_adres_i != 0) begin
      m_reg[gy_yaz_adres_i] = gy_yaz_veri_i;
      if (gy_etiket_i == m_owner[gy_yaz_adres_i]) m_busy[gy_yaz_adres_i] = 0;
    end
    if (exp_issue && u.rd_alloc && u.rd_addr != 0) begin
      m_busy[u.rd_addr]  = 1;
      m_owner[u.rd_addr] = u.tag;
    end
    m_out = exp_out;
  endtask

  // Samples the stall away from the edge, advances the model, then waits past the rising edge.
  task automatic tick();
    #1;
    obs_stall = duraklat_o;
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    coz_uop_i = '0; bosalt_i = 0; yurut_duraklat_i = 0;
    gy_yaz_gecerli_i = 0; gy_yaz_adres_i = '0; gy_yaz_veri_i = '0; gy_etiket_i = '0;
  endtask

  task automatic drive_wb(logic [4:0] a, logic [31:0] d, logic [3:0] t);
    gy_yaz_gecerli_i = 1; gy_yaz_adres_i = a; gy_yaz_veri_i = d; gy_etiket_i = t;
  endtask

  function automatic uop_t mk_uop(logic [4:0] rd, bit alloc, logic [4:0] r1, bit e1,
                                  logic [4:0] r2, bit e2, logic [31:0] imm, logic [3:0] tag);
    uop_t u;
    u = '0;
    u.valid = 1; u.tag = tag; u.rd_addr = rd; u.rd_alloc = alloc;
    u.rs1 = 32'(r1); u.rs1_en = e1; u.rs2 = 32'(r2); u.rs2_en = e2;
    u.imm = imm; u.pc = 32'h1000 + 32'(tag) * 4;
    return u;
  endfunction

  task automatic test_reset();
    rst_i = 1; drive_idle(); model_reset();
    #3;
    checks++; if (duraklat_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", duraklat_o); end
    checks++; if (yurut_uop_o !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", yurut_uop_o); end
    @(negedge clk_i); rst_i = 0;
  endtask

  task automatic test_addi();
    uop_t o;
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(5, 1, 0, 1, 0, 0, 32'd7, 4'd0);
    tick();
    o = yurut_uop_o;
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL addi_stall: got %b want 0", obs_stall); end
    checks++; if (o.valid !== 1'b1 || o.rs1 !== 32'd0 || o.imm !== 32'd7) begin errors++; $display("FAIL addi_fields: got v=%b rs1=%h imm=%h want 1/0/7", o.valid, o.rs1, o.imm); end
    checks++; if (yurut_uop_o !== exp_out) begin errors++; $display("FAIL addi_out: got %h want %h", yurut_uop_o, exp_out); end
    checks++; if (dut.mesgul[5] !== 1'b1 || dut.sahip[5] !== 4'd0) begin errors++; $display("FAIL addi_alloc: got busy=%b owner=%h want 1/0", dut.mesgul[5], dut.sahip[5]); end
  endtask

  task automatic test_raw();
    uop_t o;
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(6, 1, 5, 1, 5, 1, 32'd0, 4'd1);
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", obs_stall); end
    o = yurut_uop_o;
    checks++; if (o.valid !== 1'b0) begin errors++; $display("FAIL raw_bubble: got valid=%b want 0", o.valid); end
    @(negedge clk_i); drive_wb(5, 32'd7, 4'd0);
    tick();
    o = yurut_uop_o;
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", obs_stall); end
    checks++; if (o.valid !== 1'b1 || o.rs1 !== 32'd7 || o.rs2 !== 32'd7) begin errors++; $display("FAIL raw_operands: got v=%b rs1=%h rs2=%h want 1/7/7", o.valid, o.rs1, o.rs2); end
    checks++; if (dut.mesgul[5] !== 1'b0 || dut.mesgul[6] !== 1'b1) begin errors++; $display("FAIL raw_scoreboard: got b5=%b b6=%b want 0/1", dut.mesgul[5], dut.mesgul[6]); end
  endtask

  task automatic test_two_writers();
    uop_t o;
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(5, 1, 0, 0, 0, 0, 32'd11, 4'd2);
    drive_wb(6, 32'd33, 4'd1);
    tick();
    checks++; if (yurut_uop_o !== exp_out) begin errors++; $display("FAIL ww_first: got %h want %h", yurut_uop_o, exp_out); end
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(5, 1, 0, 0, 0, 0, 32'd22, 4'd3);
    tick();
    checks++; if (dut.sahip[5] !== 4'd3) begin errors++; $display("FAIL ww_owner: got %h want 3", dut.sahip[5]); end
    @(negedge clk_i); drive_idle(); drive_wb(5, 32'd11, 4'd2);
    tick();
    checks++; if (dut.mesgul[5] !== 1'b1) begin errors++; $display("FAIL ww_stale_tag: got busy=%b want 1", dut.mesgul[5]); end
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(7, 1, 5, 1, 6, 1, 32'd0, 4'd4);
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL ww_wait: got %b want 1", obs_stall); end
    @(negedge clk_i); drive_wb(5, 32'd22, 4'd3);
    tick();
    o = yurut_uop_o;
    checks++; if (o.valid !== 1'b1 || o.rs1 !== 32'd22 || o.rs2 !== 32'd33) begin errors++; $display("FAIL ww_operands: got v=%b rs1=%h rs2=%h want 1/22/33", o.valid, o.rs1, o.rs2); end
    checks++; if (dut.mesgul[5] !== 1'b0 || dut.u_obek.yazmaclar[5] !== 32'd22) begin errors++; $display("FAIL ww_final: got busy=%b reg=%h want 0/22", dut.mesgul[5], dut.u_obek.yazmaclar[5]); end
  endtask

  task automatic test_exec_stall();
    logic [UOP_BIT-1:0] saved;
    uop_t o;
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(8, 1, 0, 0, 0, 0, 32'h55, 4'd5);
    tick();
    saved = yurut_uop_o;
    checks++; if (saved !== exp_out) begin errors++; $display("FAIL xs_issue: got %h want %h", saved, exp_out); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); drive_idle();
      coz_uop_i = mk_uop(9, 1, 0, 0, 0, 0, 32'h66, 4'd6);
      yurut_duraklat_i = 1;
      if (c == 1) drive_wb(8, 32'd1, 4'd5);
      tick();
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL xs_stall%0d: got %b want 1", c, obs_stall); end
      checks++; if (yurut_uop_o !== saved) begin errors++; $display("FAIL xs_hold%0d: got %h want %h", c, yurut_uop_o, saved); end
      checks++; if (dut.mesgul[9] !== 1'b0) begin errors++; $display("FAIL xs_noalloc%0d: got %b want 0", c, dut.mesgul[9]); end
    end
    checks++; if (dut.mesgul[8] !== 1'b0) begin errors++; $display("FAIL xs_wb_during_stall: got %b want 0", dut.mesgul[8]); end
    @(negedge clk_i); yurut_duraklat_i = 0;
    tick();
    o = yurut_uop_o;
    checks++; if (o.valid !== 1'b1 || o.rd_addr !== 5'd9 || dut.mesgul[9] !== 1'b1) begin errors++; $display("FAIL xs_release: got v=%b rd=%0d busy=%b want 1/9/1", o.valid, o.rd_addr, dut.mesgul[9]); end
  endtask

  task automatic test_flush();
    uop_t u;
    uop_t o;
    @(negedge clk_i); drive_idle();
    u = mk_uop(3, 1, 1, 1, 0, 0, 32'd0, 4'd7);
    u.csr_adres = 12'h340; u.csr_islem = 4'd1;
    coz_uop_i = u; bosalt_i = 1;
    tick();
    o = yurut_uop_o;
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", obs_stall); end
    checks++; if (o.valid !== 1'b0 || dut.mesgul[3] !== 1'b0) begin errors++; $display("FAIL flush_drop: got v=%b busy3=%b want 0/0", o.valid, dut.mesgul[3]); end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i); drive_idle();
    coz_uop_i = mk_uop(10, 1, 9, 1, 0, 0, 32'd0, 4'd8);
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL ar_prestall: got %b want 1", obs_stall); end
    @(negedge clk_i);
    #2 rst_i = 1;
    #1;
    checks++; if (duraklat_o !== 1'b0 || yurut_uop_o !== '0) begin errors++; $display("FAIL ar_outputs: got stall=%b out=%h want 0/0", duraklat_o, yurut_uop_o); end
    checks++; if (dut.mesgul !== '0 || dut.u_obek.yazmaclar[5] !== 32'd0) begin errors++; $display("FAIL ar_state: got busy=%h x5=%h want 0/0", dut.mesgul, dut.u_obek.yazmaclar[5]); end
    drive_idle(); model_reset(); q.delete();
    @(negedge clk_i); rst_i = 0;
  endtask

  task automatic test_random();
    logic [3:0] tag_ctr;
    logic [3:0] age;
    bit         hold;
    uop_t       u;
    int         idx;
    tag_ctr = '0; hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      if (!hold) begin
        if (q.size() < 10 && $urandom_range(3) != 0) begin
          u = mk_uop(5'($urandom_range(7)), 1'($urandom_range(1)), 5'($urandom_range(7)),
                     1'($urandom_range(1)), 5'($urandom_range(7)), 1'($urandom_range(1)),
                     $urandom, tag_ctr);
          u.rs1[31:5] = 27'($urandom); u.rs2[31:5] = 27'($urandom);
          u.csr_adres = 12'($urandom); u.amb = 4'($urandom); u.dal = 4'($urandom);
          u.yaz = 1'($urandom); u.taken = 1'($urandom); u.pc = $urandom;
          coz_uop_i = u;
          tag_ctr++;
        end else coz_uop_i = '0;
      end
      yurut_duraklat_i = ($urandom_range(5) == 0);
      bosalt_i = ($urandom_range(15) == 0);
      gy_yaz_gecerli_i = 0; gy_yaz_adres_i = '0; gy_yaz_veri_i = '0; gy_etiket_i = '0;
      if (q.size() > 0) age = tag_ctr - q[0].tag; else age = '0;
      if (q.size() > 0 && (age >= 10 || $urandom_range(1) == 1)) begin
        idx = (age >= 10) ? 0 : $urandom_range(q.size() - 1);
        drive_wb(q[idx].rd, $urandom, q[idx].tag);
        q.delete(idx);
      end else if ($urandom_range(7) == 0) begin
        drive_wb(5'd0, $urandom, 4'($urandom));
      end
      tick();
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, obs_stall, exp_stall); end
      checks++; if (yurut_uop_o !== exp_out) begin errors++; $display("FAIL rnd_out c%0d: got %h want %h", c, yurut_uop_o, exp_out); end
      u = coz_uop_i;
      if (exp_issue && u.rd_alloc && u.rd_addr != 0) q.push_back('{rd: u.rd_addr, tag: u.tag});
      hold = obs_stall;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_two_writers();
    test_exec_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
